// File: rtl/vote_pkg.sv
// Shared definitions for the voting front end and the vote logger:
// candidate count, FSM states and default timing values.
package vote_pkg;

    localparam int NUM_CAND            = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_LOCKOUT_CYCLES  = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        LOCKOUT      = 2'd2
    } vote_state_t;

    // True when exactly one bit of the button vector is set.
    function automatic logic is_single(input logic [NUM_CAND-1:0] v);
        return (v != '0) && ((v & (v - NUM_CAND'(1))) == '0);
    endfunction

endpackage

// File: rtl/vote_debounce.sv
// One-bit two-flop synchronizer followed by a saturating debouncer whose
// level changes only after DEBOUNCE_CYCLES consecutive cycles of a new value.
module vote_debounce
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // stage p0/p1: metastability guard for the asynchronous button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= button;
            sync_p1 <= sync_p0;
        end
    end

    // Any return to the current level restarts the count; count stops at CNT_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_p1 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= sync_p1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vote_button_ctrl.sv
// Voting button front end: debounces four candidate buttons and emits one
// registered pulse per accepted press, with release wait and lockout.
module vote_button_ctrl
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic mode,
    input  logic button1,
    input  logic button2,
    input  logic button3,
    input  logic button4,
    output logic cand1_valid_vote,
    output logic cand2_valid_vote,
    output logic cand3_valid_vote,
    output logic cand4_valid_vote,
    output logic invalid_press,
    output logic busy
);

    localparam int               LCK_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_CAND-1:0] buttons;
    logic [NUM_CAND-1:0] levels;

    vote_state_t         state;
    vote_state_t         state_next;
    logic [LCK_W-1:0]    lock_cnt;
    logic [LCK_W-1:0]    lock_cnt_next;
    logic [NUM_CAND-1:0] cand_q;
    logic [NUM_CAND-1:0] cand_next;
    logic                invalid_q;
    logic                invalid_next;

    assign buttons = {button4, button3, button2, button1};

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_deb
        vote_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .button(buttons[i]),
            .level (levels[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            cand_q    <= '0;
            invalid_q <= 1'b0;
        end else begin
            state     <= state_next;
            lock_cnt  <= lock_cnt_next;
            cand_q    <= cand_next;
            invalid_q <= invalid_next;
        end
    end

    // mode is only looked at on the IDLE exit, so later changes cannot alter a press.
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        cand_next     = '0;
        invalid_next  = 1'b0;
        case (state)
            IDLE: begin
                if (levels != '0) begin
                    state_next = WAIT_RELEASE;
                    if (!mode) begin
                        if (is_single(levels)) begin
                            cand_next = levels;
                        end else begin
                            invalid_next = 1'b1;
                        end
                    end
                end
            end
            WAIT_RELEASE: begin
                if (levels == '0) begin
                    state_next    = LOCKOUT;
                    lock_cnt_next = '0;
                end
            end
            LOCKOUT: begin
                lock_cnt_next = lock_cnt + LCK_W'(1);
                if (lock_cnt == LCK_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cand1_valid_vote = cand_q[0];
    assign cand2_valid_vote = cand_q[1];
    assign cand3_valid_vote = cand_q[2];
    assign cand4_valid_vote = cand_q[3];
    assign invalid_press    = invalid_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_vote_button_ctrl.sv
// Directed bench for vote_button_ctrl: expected pulses are queued with their
// edge number when a press is driven and matched as the DUT emits them.
module tb_vote_button_ctrl;
    import vote_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic button1 = 1'b0;
    logic button2 = 1'b0;
    logic button3 = 1'b0;
    logic button4 = 1'b0;
    logic cand1_valid_vote;
    logic cand2_valid_vote;
    logic cand3_valid_vote;
    logic cand4_valid_vote;
    logic invalid_press;
    logic busy;

    vote_button_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .button1         (button1),
        .button2         (button2),
        .button3         (button3),
        .button4         (button4),
        .cand1_valid_vote(cand1_valid_vote),
        .cand2_valid_vote(cand2_valid_vote),
        .cand3_valid_vote(cand3_valid_vote),
        .cand4_valid_vote(cand4_valid_vote),
        .invalid_press   (invalid_press),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic push(input int cyc, input logic [4:0] vec);
        exp_t e;
        e.cyc = cyc;
        e.vec = vec;
        q.push_back(e);
    endtask

    // One clock: sample on the falling edge and match against the scoreboard.
    task automatic tick();
        logic [4:0] obs;
        exp_t       e;
        @(negedge clk);
        obs = {invalid_press, cand4_valid_vote, cand3_valid_vote,
               cand2_valid_vote, cand1_valid_vote};
        if (q.size() > 0 && q[0].cyc <= edge_n) begin
            e = q.pop_front();
            chk($sformatf("pulse_at_edge_%0d", e.cyc), {27'd0, obs}, {27'd0, e.vec});
        end else if (obs != 5'd0) begin
            chk("unexpected_pulse", {27'd0, obs}, 32'd0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic until_edge(input int e);
        while (edge_n < e) tick();
    endtask

    initial begin
        int t0;
        int t1;
        int t2;

        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", {27'd0, invalid_press, cand4_valid_vote, cand3_valid_vote,
                              cand2_valid_vote, cand1_valid_vote}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_state", {30'd0, dut.state}, {30'd0, IDLE});
        run(3);
        rst = 1'b1;
        run(2);

        // single press, button2 held 40 cycles
        t0 = edge_n;
        button2 = 1'b1;
        push(t0 + 20, 5'b00010);
        until_edge(t0 + 19);
        chk("b2_busy_before_pulse", {31'd0, busy}, 32'd0);
        tick();
        chk("b2_busy_at_pulse", {31'd0, busy}, 32'd1);
        until_edge(t0 + 40);
        button2 = 1'b0;
        t1 = edge_n;
        until_edge(t1 + 27);
        chk("b2_busy_end_lockout", {31'd0, busy}, 32'd1);
        tick();
        chk("b2_busy_after_lockout", {31'd0, busy}, 32'd0);

        // simultaneous button1 + button3
        t0 = edge_n;
        button1 = 1'b1;
        button3 = 1'b1;
        push(t0 + 20, 5'b10000);
        until_edge(t0 + 20);
        chk("multi_busy", {31'd0, busy}, 32'd1);
        chk("multi_state", {30'd0, dut.state}, {30'd0, WAIT_RELEASE});
        until_edge(t0 + 30);
        button1 = 1'b0;
        button3 = 1'b0;
        t1 = edge_n;
        until_edge(t1 + 28);
        chk("multi_idle", {31'd0, busy}, 32'd0);

        // button4 bouncing faster than the debounce window
        for (int i = 0; i < 20; i++) begin
            button4 = ~button4;
            run(5);
            chk("bounce_busy", {31'd0, busy}, 32'd0);
        end
        run(20);
        chk("bounce_busy_settled", {31'd0, busy}, 32'd0);

        // display mode consumes the press; mode drop afterwards has no effect
        mode = 1'b1;
        t0 = edge_n;
        button1 = 1'b1;
        until_edge(t0 + 20);
        chk("mode1_busy", {31'd0, busy}, 32'd1);
        until_edge(t0 + 25);
        mode = 1'b0;
        until_edge(t0 + 30);
        button1 = 1'b0;
        t1 = edge_n;
        until_edge(t1 + 28);
        chk("mode1_idle", {31'd0, busy}, 32'd0);
        t2 = edge_n;
        button1 = 1'b1;
        push(t2 + 20, 5'b00001);
        until_edge(t2 + 25);
        button1 = 1'b0;
        t1 = edge_n;
        until_edge(t1 + 28);
        chk("mode0_idle", {31'd0, busy}, 32'd0);

        // button3 re-pressed three cycles into lockout and held
        t0 = edge_n;
        button3 = 1'b1;
        push(t0 + 20, 5'b00100);
        until_edge(t0 + 25);
        button3 = 1'b0;
        t1 = edge_n;
        until_edge(t1 + 20);
        chk("repress_lockout_state", {30'd0, dut.state}, {30'd0, LOCKOUT});
        until_edge(t1 + 23);
        button3 = 1'b1;
        t2 = edge_n;
        push(t2 + 20, 5'b00100);
        until_edge(t1 + 28);
        chk("repress_idle_reentered", {31'd0, busy}, 32'd0);
        until_edge(t2 + 19);
        chk("repress_busy_before", {31'd0, busy}, 32'd0);
        tick();
        chk("repress_busy_at_pulse", {31'd0, busy}, 32'd1);
        run(20);
        button3 = 1'b0;
        t1 = edge_n;
        until_edge(t1 + 28);
        chk("repress_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of a button2 debounce
        t0 = edge_n;
        button2 = 1'b1;
        until_edge(t0 + 5);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {27'd0, invalid_press, cand4_valid_vote, cand3_valid_vote,
                               cand2_valid_vote, cand1_valid_vote}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        run(3);
        chk("midrst_level", {28'd0, dut.levels}, 32'd0);
        rst = 1'b1;
        t1 = edge_n;
        push(t1 + 20, 5'b00010);
        until_edge(t1 + 19);
        chk("midrst_busy_before", {31'd0, busy}, 32'd0);
        tick();
        chk("midrst_busy_at_pulse", {31'd0, busy}, 32'd1);
        until_edge(t1 + 30);
        button2 = 1'b0;
        t2 = edge_n;
        until_edge(t2 + 28);
        chk("midrst_idle", {31'd0, busy}, 32'd0);

        run(5);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
